// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Used by keypad_scan_4x4 and keypad_row_sync.
package keypad_pkg;

  // Scanner controller states
  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } kp_state_t;

  // Column drive after reset: column 0 selected (one-cold)
  localparam logic [3:0] COL_RESET = 4'b1110;

  // Row return with no key pressed (pull-ups)
  localparam logic [3:0] ROW_IDLE  = 4'b1111;

  // Key codes packed as 16 nibbles, nibble index = row*4 + col.
  //   r0: 1 2 3 A   r1: 4 5 6 B   r2: 7 8 9 C   r3: E(*) 0 F(#) D
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;

  // Hex code for the key at (row, col)
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [5:0] base;
    base = {row, col, 2'b00};
    return KEY_MAP[base +: 4];
  endfunction

  // Index of the lowest-numbered row reading low; only meaningful when
  // at least one row is low.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rs);
    logic [1:0] idx;
    if (!rs[0])      idx = 2'd0;
    else if (!rs[1]) idx = 2'd1;
    else if (!rs[2]) idx = 2'd2;
    else             idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_4x4_if.sv
// Keypad matrix and key-event signals of keypad_scan_4x4.
// master: the scanner; slave: the keypad matrix plus key consumer.
interface keypad_scan_4x4_if;

  logic [3:0] row_n;     // rows, active-low, asynchronous to clk
  logic [3:0] col_n;     // one-cold column drive
  logic [3:0] key_code;  // last accepted key
  logic       key_valid; // one-cycle pulse on key_code update
  logic       key_held;  // accepted key still pressed

  modport master (
    input  row_n,
    output col_n,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row_n,
    input  col_n,
    input  key_code,
    input  key_valid,
    input  key_held
  );

endinterface

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row returns.
// Resets to all-high so an idle keypad is seen immediately after reset.
module keypad_row_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] rs
);

  logic [3:0] meta;

  // Two-stage capture of row_n into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= ROW_IDLE;
      rs   <= ROW_IDLE;
    end else begin
      meta <= row_n;
      rs   <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan_4x4.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Drives one-cold columns, samples synchronized rows on the last dwell
// cycle, debounces the captured key and emits a hex code with a
// one-cycle valid pulse.
// Optional build macro: KEYPAD_REPEAT_EN (auto-repeat every REPEAT_CYC
// cycles while a key stays accepted).
module keypad_scan_4x4
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned DEBOUNCE_CYC = 100000,
  parameter int unsigned REPEAT_CYC   = 5000000
) (
  input logic              clk,
  input logic              rst,
  keypad_scan_4x4_if.master kp
);

  localparam int unsigned MAX_BASE = (SCAN_DIV > DEBOUNCE_CYC) ? SCAN_DIV : DEBOUNCE_CYC;
`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned MAX_CNT  = (REPEAT_CYC > MAX_BASE) ? REPEAT_CYC : MAX_BASE;
`else
  // Repeat period does not size the counters when repeat is disabled
  localparam int unsigned MAX_CNT  = MAX_BASE + (REPEAT_CYC * 0);
`endif
  localparam int unsigned CNT_W    = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

  logic [3:0]       rs;
  kp_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       col_idx;
  logic [1:0]       row_idx;
  logic             row_bit;
  logic [3:0]       col_n_q;
  logic [3:0]       key_code_q;
  logic             key_valid_q;
  logic             key_held_q;
`ifdef KEYPAD_REPEAT_EN
  logic [CNT_W-1:0] rep_cnt;
  logic [CNT_W-1:0] rep_inc;
`endif

  keypad_row_sync u_row_sync (
    .clk   (clk),
    .rst   (rst),
    .row_n (kp.row_n),
    .rs    (rs)
  );

  // Saturating increments and the captured row's synchronized level
  always_comb begin
    cnt_inc = (cnt == '1) ? cnt : cnt + CNT_W'(1);
`ifdef KEYPAD_REPEAT_EN
    rep_inc = (rep_cnt == '1) ? rep_cnt : rep_cnt + CNT_W'(1);
`endif
    row_bit = rs[row_idx];
  end

  // Scan / debounce controller with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SCAN;
      cnt         <= '0;
      col_idx     <= '0;
      row_idx     <= '0;
      col_n_q     <= COL_RESET;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt     <= '0;
`endif
    end else begin
      key_valid_q <= 1'b0;
      unique case (state)
        SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (rs != ROW_IDLE) begin
              // Column stays frozen on the key's column while debouncing
              row_idx <= lowest_low_row(rs);
              state   <= DEB_PRESS;
            end else begin
              col_idx <= col_idx + 2'd1;
              col_n_q <= {col_n_q[2:0], col_n_q[3]};
            end
          end else begin
            cnt <= cnt_inc;
          end
        end

        DEB_PRESS: begin
          if (row_bit) begin
            // Bounce: abandon this column and keep scanning
            state   <= SCAN;
            cnt     <= '0;
            col_idx <= col_idx + 2'd1;
            col_n_q <= {col_n_q[2:0], col_n_q[3]};
          end else if (cnt == DEB_LAST) begin
            state       <= PRESSED;
            cnt         <= '0;
            key_code_q  <= key_map(row_idx, col_idx);
            key_valid_q <= 1'b1;
            key_held_q  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt     <= '0;
`endif
          end else begin
            cnt <= cnt_inc;
          end
        end

        PRESSED: begin
          if (row_bit) begin
            state <= DEB_RELEASE;
            cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt <= '0;
          end else if (rep_cnt == REP_LAST) begin
            key_valid_q <= 1'b1;
            rep_cnt     <= '0;
          end else begin
            rep_cnt <= rep_inc;
`endif
          end
        end

        DEB_RELEASE: begin
          if (!row_bit) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state      <= SCAN;
            cnt        <= '0;
            key_held_q <= 1'b0;
            col_idx    <= col_idx + 2'd1;
            col_n_q    <= {col_n_q[2:0], col_n_q[3]};
          end else begin
            cnt <= cnt_inc;
          end
        end

        default: begin
          state <= SCAN;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign kp.col_n     = col_n_q;
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_4x4.sv
// Scoreboard testbench for keypad_scan_4x4 (SCAN_DIV=4, DEBOUNCE_CYC=8,
// REPEAT_CYC=16). Define KEYPAD_REPEAT_EN for the repeat build.
module tb_keypad_scan_4x4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  keypad_scan_4x4_if kif ();

  keypad_scan_4x4 #(
    .SCAN_DIV     (4),
    .DEBOUNCE_CYC (8),
    .REPEAT_CYC   (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kif)
  );

  // Keypad matrix model: pressed[r*4+c] pulls row r low while column c is driven
  logic [15:0] pressed = '0;
  logic        ovr_en  = 1'b0;
  logic [3:0]  ovr_val = 4'b1111;
  logic [3:0]  row_model;

  always_comb begin
    row_model = 4'b1111;
    for (int unsigned r = 0; r < 4; r++)
      for (int unsigned c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kif.col_n[c]) row_model[r] = 1'b0;
    kif.row_n = ovr_en ? ovr_val : row_model;
  end

  int         n_cmp = 0;
  int         n_err = 0;
  logic [3:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every key_valid pulse pops one expected code
  initial begin : monitor
    logic prev_v;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (kif.key_valid === 1'b1) begin
        check("valid_gap", {31'd0, prev_v}, 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_valid: got pulse with code %0h expected no pulse", kif.key_code);
        end else begin
          check("key_code", {28'd0, kif.key_code}, {28'd0, exp_q.pop_front()});
        end
      end
      prev_v = kif.key_valid;
    end
  end

  task automatic wait_held(input logic v, input string name);
    logic seen;
    seen = 1'b0;
    for (int unsigned i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (kif.key_held === v) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic wait_col(input logic [3:0] col, input string name);
    logic seen;
    seen = 1'b0;
    for (int unsigned i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (kif.col_n === col) seen = 1'b1;
    end
    check(name, {31'd0, seen}, 32'd1);
  endtask

  task automatic measure_step(output int n, output logic [3:0] nc);
    logic [3:0] c0;
    c0 = kif.col_n;
    n  = 0;
    do begin
      @(negedge clk);
      n++;
    end while (kif.col_n === c0 && n < 40);
    nc = kif.col_n;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_col"},   {28'd0, kif.col_n},    32'hE);
    check({tag, "_code"},  {28'd0, kif.key_code}, 32'h0);
    check({tag, "_valid"}, {31'd0, kif.key_valid}, 32'd0);
    check({tag, "_held"},  {31'd0, kif.key_held},  32'd0);
  endtask

  int          key_idx[3] = '{12, 14, 15};
  logic [3:0]  key_exp[3] = '{4'hE, 4'hF, 4'hD};

  initial begin : stimulus
    int         n;
    logic [3:0] nc;
    logic [3:0] pc;
    logic       dropped;

    // 1. Reset and idle scan rotation
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst = 1'b0;
    measure_step(n, nc);
    for (int unsigned k = 0; k < 2; k++) begin
      pc = nc;
      measure_step(n, nc);
      check("scan_period", n, 32'd4);
      check("scan_order", {28'd0, nc}, {28'd0, pc[2:0], pc[3]});
    end

    // 2. Key 5: accept, then release timing and scan resume
    exp_q.push_back(4'h5);
    pressed[5] = 1'b1;
    wait_held(1'b1, "k5_held");
    check("k5_col", {28'd0, kif.col_n}, 32'hD);
    check("k5_code", {28'd0, kif.key_code}, 32'h5);
    pressed[5] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (kif.key_held === 1'b1 && n < 40);
    check("k5_release_lat", n, 32'd11);
    check("k5_resume_col", {28'd0, kif.col_n}, 32'hB);

    // 3. Three-cycle bounce on row 0 at column 0
    wait_col(4'b1110, "bounce_find_col0");
    ovr_en  = 1'b1;
    ovr_val = 4'b1110;
    repeat (3) @(negedge clk);
    ovr_en = 1'b0;
    @(negedge clk);
    check("bounce_frozen", {28'd0, kif.col_n}, 32'hE);
    repeat (2) @(negedge clk);
    check("bounce_resume", {28'd0, kif.col_n}, 32'hD);

    // 4. Keys 2 and 8 together, partial release, then *, #, D
    exp_q.push_back(4'h2);
    pressed[1] = 1'b1;
    pressed[9] = 1'b1;
    wait_held(1'b1, "k2k8_held");
    check("k2k8_code", {28'd0, kif.key_code}, 32'h2);
    pressed[9] = 1'b0;
    repeat (10) @(negedge clk);
    check("k8_release_held", {31'd0, kif.key_held}, 32'd1);
    pressed[1] = 1'b0;
    wait_held(1'b0, "k2_released");
    for (int unsigned k = 0; k < 3; k++) begin
      exp_q.push_back(key_exp[k]);
      pressed[key_idx[k]] = 1'b1;
      wait_held(1'b1, "seq_held");
      check("seq_code", {28'd0, kif.key_code}, {28'd0, key_exp[k]});
      pressed[key_idx[k]] = 1'b0;
      wait_held(1'b0, "seq_released");
    end

    // 5. Five-cycle release glitch while key 1 is accepted
    exp_q.push_back(4'h1);
    pressed[0] = 1'b1;
    wait_held(1'b1, "k1_held");
    pressed[0] = 1'b0;
    repeat (5) @(negedge clk);
    pressed[0] = 1'b1;
    dropped = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (kif.key_held !== 1'b1) dropped = 1'b1;
    end
    check("glitch_held", {31'd0, dropped}, 32'd0);
    pressed[0] = 1'b0;
    wait_held(1'b0, "k1_released");

    // 6a. Reset four cycles into press debounce of key 9
    wait_col(4'b1011, "k9_find_col2");
    pressed[10] = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_deb");
    pressed[10] = 1'b0;
    rst = 1'b0;

    // 6b. Hold key 0 for 40 cycles after accept, then reset while pressed
    exp_q.push_back(4'h0);
`ifdef KEYPAD_REPEAT_EN
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h0);
`endif
    pressed[13] = 1'b1;
    wait_held(1'b1, "k0_held");
    check("k0_code", {28'd0, kif.key_code}, 32'h0);
    repeat (39) @(negedge clk);
    check("k0_still_held", {31'd0, kif.key_held}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_pressed");
    pressed[13] = 1'b0;
    rst = 1'b0;
    repeat (30) @(negedge clk);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/keypad_scan_4x4.md
Name: keypad_scan_4x4

Overview:
Input-side counterpart of the multiplexed 7-segment display driver. It scans a 4x4 matrix keypad by driving one-cold column selects and reading the row returns. Row reads are synchronized and debounced. Each accepted press produces a 4-bit hex key code with a one-cycle valid pulse, which feeds the adder/subtractor operand registers.

Parameters:
SCAN_DIV, 1000, clk cycles each column is driven (dwell); minimum 4.
DEBOUNCE_CYC, 100000, consecutive stable cycles required to accept a press or a release.
REPEAT_CYC, 5000000, auto-repeat period in cycles; used only with KEYPAD_REPEAT_EN.

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
row_n  input  4  keypad rows; active-low, external pull-ups, asynchronous to clk
col_n  output  4  one-cold column drive; 0 = column selected
key_code  output  4  hex code of the last accepted key
key_valid  output  1  one-cycle pulse when key_code is updated
key_held  output  1  high while the accepted key remains pressed

Behaviour:
- Reset values: col_n=4'b1110, key_code=4'h0, key_valid=0, key_held=0, state=SCAN, counters=0, synchronizer=4'b1111.
- row_n passes through a 2-FF synchronizer (reset to 1111). All decisions use the synchronized value rs. Latency is 2 cycles.
- Key map, indexed row r / col c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E(*) 0 F(#) D
- Counter width: $clog2 of the largest used parameter. Counters saturate and never wrap.
- SCAN:
  - Dwell counter runs 0..SCAN_DIV-1. rs is sampled only on the last dwell cycle, which gives settle time.
  - If any rs bit is 0: capture col and the lowest-index low row, clear the counter, go to DEB_PRESS. The column stays frozen.
  - Otherwise rotate the column (1110 -> 1101 -> 1011 -> 0111 -> 1110).
- DEB_PRESS:
  - If the captured row bit is 1 on any cycle: go to SCAN and advance the column. No output.
  - After DEBOUNCE_CYC consecutive low cycles: go to PRESSED. On that same edge key_code is loaded from the map, key_valid=1 for exactly one cycle, and key_held=1.
- PRESSED:
  - Column stays frozen; other keys are ignored.
  - When the captured row bit reads 1: clear the counter, go to DEB_RELEASE.
- DEB_RELEASE:
  - If the bit reads 0 again: return to PRESSED with no new pulse.
  - After DEBOUNCE_CYC consecutive high cycles: key_held=0, go to SCAN and advance the column.
  - key_code keeps its last value.
- Simultaneous keys:
  - Same column: lowest row wins. Releasing a non-captured key has no effect.
  - Different columns: the first column scanned wins.
- rst at any state: all reset values apply on the next edge. An in-flight debounce is discarded and no key_valid is issued.
- key_valid is never high on two consecutive cycles.

Optional Feature:
KEYPAD_REPEAT_EN
- Defined: in PRESSED, a repeat counter starts at the accept pulse. Every REPEAT_CYC cycles it issues another one-cycle key_valid with the unchanged key_code. The counter clears on leaving PRESSED, and DEB_RELEASE does not repeat.
- Undefined: no repeat logic is synthesized and REPEAT_CYC is ignored. Exactly one key_valid per press.

Decomposition:
- Package keypad_pkg:
  - state enum {SCAN, DEB_PRESS, PRESSED, DEB_RELEASE}
  - 16-entry key-map localparam function
  - COL_RESET=4'b1110
- One sub-module, keypad_row_sync: 4-bit 2-FF synchronizer with synchronous reset to 1111. Debounce and scan counters stay in the top module.

Test Plan:
Bench uses SCAN_DIV=4, DEBOUNCE_CYC=8, REPEAT_CYC=16.
1. rst high 3 cycles, rows idle 1111 -> col_n=1110, key_code=0, key_valid=0, key_held=0. Column rotates every 4 cycles after release.
2. Press key 5 (row_n[1]=0 only while col_n=1101) -> col freezes at 1101, one key_valid pulse, key_code=4'h5, key_held=1. Release -> key_held=0 exactly 8 cycles after the synchronized release, then scanning resumes.
3. Bounce: row_n[0]=0 for 3 cycles at col 0 -> no key_valid, scanning resumes at col_n=1101.
4. Press keys 2 and 8 together (col 1, rows 0 and 2) -> key_code=4'h2. Release 8 only -> still held, no new pulse. Press *, #, D in turn -> codes E, F, D.
5. Release glitch: in PRESSED, row high for 5 cycles then low -> key_held stays 1, no pulse.
6. rst asserted 4 cycles into DEB_PRESS and again during PRESSED -> all reset values next edge, no key_valid. With KEYPAD_REPEAT_EN, holding key 0 for 40 cycles after accept -> key_valid at +0, +16, +32, each with key_code=4'h0.
